// File: rtl/apb_slave_pkg20.sv
// Shared types and constants for the APB3 responder and its register file.
package apb_slave_pkg20;

    localparam int unsigned DATA_W            = 32;
    localparam int unsigned WAIT_W            = 4;

    localparam int unsigned REG_CTRL          = 0;
    localparam int unsigned REG_ID            = 1;
    localparam int unsigned REG_XFER_CNT      = 2;
    localparam int unsigned REG_FIRST_SCRATCH = 3;

    localparam logic [DATA_W-1:0] ID_VALUE    = 32'h4150_4253;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

endpackage

// File: rtl/apb_slave_regfile20.sv
// Register storage for the APB responder: read/error decode at setup,
// write commit and transfer counting at completion.
module apb_slave_regfile20
    import apb_slave_pkg20::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [ADDR_W-3:0]             rd_word_i,
    input  logic                          rd_write_i,
    output logic [DATA_W-1:0]             rd_data_o,
    output logic                          rd_err_o,
    output logic [WAIT_W-1:0]             ctrl_wait_o,
    input  logic                          commit_i,
    input  logic                          commit_wr_i,
    input  logic [$clog2(NUM_REGS)-1:0]   commit_idx_i,
    input  logic [DATA_W-1:0]             commit_wdata_i
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    logic [WAIT_W-1:0] ctrl_q;
    logic [DATA_W-1:0] xfer_cnt_q;
    logic [DATA_W-1:0] xfer_cnt_d;
    logic [DATA_W-1:0] scratch_q [NUM_REGS];

    logic              in_range_c;
    logic [IDX_W-1:0]  rd_idx_c;
    logic              ro_hit_c;

    assign in_range_c  = rd_word_i < (ADDR_W-2)'(NUM_REGS);
    assign rd_idx_c    = rd_word_i[IDX_W-1:0];
    assign ro_hit_c    = (rd_idx_c == IDX_W'(REG_ID)) || (rd_idx_c == IDX_W'(REG_XFER_CNT));
    assign rd_err_o    = !in_range_c || (rd_write_i && ro_hit_c);
    assign ctrl_wait_o = ctrl_q;
    assign xfer_cnt_d  = xfer_cnt_q + 32'd1;

    // Read mux; out-of-range words read as zero.
    always_comb begin
        rd_data_o = '0;
        if (in_range_c) begin
            if (rd_idx_c == IDX_W'(REG_CTRL)) begin
                rd_data_o = {{(DATA_W-WAIT_W){1'b0}}, ctrl_q};
            end else if (rd_idx_c == IDX_W'(REG_ID)) begin
                rd_data_o = ID_VALUE;
            end else if (rd_idx_c == IDX_W'(REG_XFER_CNT)) begin
                rd_data_o = xfer_cnt_q;
            end else begin
                rd_data_o = scratch_q[rd_idx_c];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_q     <= '0;
            xfer_cnt_q <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                scratch_q[i] <= '0;
            end
        end else begin
            if (commit_i) begin
                xfer_cnt_q <= xfer_cnt_d;
            end
            // commit_wr_i is already qualified with the error decode.
            if (commit_i && commit_wr_i) begin
                if (commit_idx_i == IDX_W'(REG_CTRL)) begin
                    ctrl_q <= commit_wdata_i[WAIT_W-1:0];
                end else if (commit_idx_i >= IDX_W'(REG_FIRST_SCRATCH)) begin
                    scratch_q[commit_idx_i] <= commit_wdata_i;
                end
            end
        end
    end

endmodule

// File: rtl/apb_slave_responder20.sv
// APB3 completer: setup/access FSM with programmable wait states, registered
// response outputs, backed by apb_slave_regfile20.
module apb_slave_responder20
    import apb_slave_pkg20::*;
#(
    parameter int unsigned PADDR_WIDTH20  = 32,
    parameter int unsigned PWDATA_WIDTH20 = 32,
    parameter int unsigned PRDATA_WIDTH20 = 32,
    parameter int unsigned NUM_REGS20     = 16,
    parameter int unsigned SEL_INDEX20    = 0
) (
    input  logic                      pclock20,
    input  logic                      preset20,
    input  logic [PADDR_WIDTH20-1:0]  paddr20,
    input  logic                      prwd20,
    input  logic [PWDATA_WIDTH20-1:0] pwdata20,
    input  logic                      penable20,
    input  logic [15:0]               psel20,
    output logic [PRDATA_WIDTH20-1:0] prdata20,
    output logic                      pready20,
    output logic                      pslverr20
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS20);

    state_e                    state_q;
    logic [WAIT_W-1:0]         wait_q;
    logic [IDX_W-1:0]          idx_q;
    logic                      write_q;
    logic [PWDATA_WIDTH20-1:0] wdata_q;
    logic                      err_q;
    logic [PRDATA_WIDTH20-1:0] hold_q;
    logic                      pready_q;
    logic                      pslverr_q;
    logic [PRDATA_WIDTH20-1:0] prdata_q;

    logic                      sel_c;
    logic                      complete_c;
    logic [DATA_W-1:0]         rd_data_c;
    logic                      rd_err_c;
    logic [WAIT_W-1:0]         ctrl_wait_c;
    logic [PRDATA_WIDTH20-1:0] setup_rdata_c;
    logic                      unused_c;

    assign sel_c         = psel20[4'(SEL_INDEX20)];
    assign complete_c    = (state_q == ST_ACCESS) && sel_c && penable20 && pready_q;
    assign setup_rdata_c = (!prwd20 && !rd_err_c) ? rd_data_c : '0;
    assign unused_c      = ^{paddr20[1:0], psel20};

    assign prdata20  = prdata_q;
    assign pready20  = pready_q;
    assign pslverr20 = pslverr_q;

    apb_slave_regfile20 #(
        .ADDR_W   (PADDR_WIDTH20),
        .NUM_REGS (NUM_REGS20)
    ) u_regfile (
        .clk_i          (pclock20),
        .rst_n_i        (preset20),
        .rd_word_i      (paddr20[PADDR_WIDTH20-1:2]),
        .rd_write_i     (prwd20),
        .rd_data_o      (rd_data_c),
        .rd_err_o       (rd_err_c),
        .ctrl_wait_o    (ctrl_wait_c),
        .commit_i       (complete_c),
        .commit_wr_i    (write_q && !err_q),
        .commit_idx_i   (idx_q),
        .commit_wdata_i (wdata_q)
    );

    always_ff @(posedge pclock20 or negedge preset20) begin
        if (!preset20) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            hold_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Only a proper setup phase starts a transfer.
                    if (sel_c && !penable20) begin
                        state_q <= ST_ACCESS;
                        idx_q   <= paddr20[IDX_W+1:2];
                        write_q <= prwd20;
                        wdata_q <= pwdata20;
                        err_q   <= rd_err_c;
                        hold_q  <= setup_rdata_c;
                        wait_q  <= ctrl_wait_c;
                        if (ctrl_wait_c == '0) begin
                            pready_q  <= 1'b1;
                            prdata_q  <= setup_rdata_c;
                            pslverr_q <= rd_err_c;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (complete_c || !sel_c || !penable20) begin
                        state_q   <= ST_IDLE;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                        prdata_q  <= '0;
                    end else if (wait_q != '0) begin
                        wait_q <= wait_q - WAIT_W'(1);
                        if (wait_q == WAIT_W'(1)) begin
                            pready_q  <= 1'b1;
                            prdata_q  <= hold_q;
                            pslverr_q <= err_q;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
